updown_mod_counter: RTL and testbench

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

---
 rtl/updown_mod_counter.sv | 87 ++++++++
 tb/tb_updown_mod_counter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// -----------------------------------------------------------------------------
// updown_mod_counter : prescaled up/down modulo counter, wrap or saturate mode
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module updown_mod_counter #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] MOD_MAX  = {WIDTH{1'b1}},
  parameter int               SATURATE = 0,
  parameter int               PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] dout,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  localparam int              PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] C_PS_LAST = PS_W'(PRESCALE - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PS_W-1:0]  psc_q, psc_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic             w_tc;

  // Terminal count doubles as the "at limit for this direction" condition.
  assign w_tc = up ? (cnt_q == MOD_MAX) : (cnt_q == '0);

  always_comb begin
    cnt_d  = cnt_q;
    psc_d  = psc_q;
    wrap_d = 1'b0;
    sat_d  = 1'b0;
    if (clear) begin
      cnt_d = '0;
      psc_d = '0;
    end else if (load) begin
      cnt_d = (load_val > MOD_MAX) ? MOD_MAX : load_val;
      psc_d = '0;
    end else if (en) begin
      if (psc_q == C_PS_LAST) begin
        psc_d = '0;
        if (!w_tc) begin
          cnt_d = up ? (cnt_q + WIDTH'(1)) : (cnt_q - WIDTH'(1));
        end else if (SATURATE != 0) begin
          sat_d = 1'b1;
        end else begin
          cnt_d  = up ? '0 : MOD_MAX;
          wrap_d = 1'b1;
        end
      end else begin
        psc_d = psc_q + PS_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      psc_q  <= '0;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      psc_q  <= psc_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  assign dout = cnt_q;
  assign tc   = w_tc;
  assign wrap = wrap_q;
  assign sat  = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_updown_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_updown_mod_counter : three counter variants (wrap, saturate, prescale 3)
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_updown_mod_counter;

  localparam int MAXV = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [2:0][3:0] dout_a;
  logic [2:0]      tc_a, wrap_a, sat_a;

  int  n_checks = 0;
  int  n_err    = 0;
  bit  chk_en   = 1'b0;

  int m_cnt [3];
  int m_psc [3];
  bit m_wrap[3];
  bit m_sat [3];

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MOD_MAX(4'd9), .SATURATE(0), .PRESCALE(1)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .dout(dout_a[0]), .tc(tc_a[0]), .wrap(wrap_a[0]), .sat(sat_a[0]));

  updown_mod_counter #(.WIDTH(4), .MOD_MAX(4'd9), .SATURATE(1), .PRESCALE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .dout(dout_a[1]), .tc(tc_a[1]), .wrap(wrap_a[1]), .sat(sat_a[1]));

  updown_mod_counter #(.WIDTH(4), .MOD_MAX(4'd9), .SATURATE(0), .PRESCALE(3)) u_psc (
    .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .dout(dout_a[2]), .tc(tc_a[2]), .wrap(wrap_a[2]), .sat(sat_a[2]));

  // Reference behaviour: count lives in 0..MAXV, an out-of-range step either
  // folds modulo MAXV+1 or is refused.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int  c, p, t, ps;
      bit  w, s;
      ps = (k == 2) ? 3 : 1;
      c  = m_cnt[k];
      p  = m_psc[k];
      w  = 1'b0;
      s  = 1'b0;
      if (rst) begin
        c = 0;
        p = 0;
      end else if (clear) begin
        c = 0;
        p = 0;
      end else if (load) begin
        c = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
        p = 0;
      end else if (en) begin
        if (p + 1 == ps) begin
          p = 0;
          t = up ? c + 1 : c - 1;
          if (t < 0 || t > MAXV) begin
            if (k == 1) s = 1'b1;
            else begin
              c = (t + MAXV + 1) % (MAXV + 1);
              w = 1'b1;
            end
          end else begin
            c = t;
          end
        end else begin
          p = p + 1;
        end
      end
      m_cnt[k]  <= c;
      m_psc[k]  <= p;
      m_wrap[k] <= w;
      m_sat[k]  <= s;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        bit exp_tc;
        exp_tc = up ? (m_cnt[k] == MAXV) : (m_cnt[k] == 0);
        n_checks = n_checks + 1;
        if (int'(dout_a[k]) != m_cnt[k] || tc_a[k] != exp_tc ||
            wrap_a[k] != m_wrap[k] || sat_a[k] != m_sat[k]) begin
          n_err = n_err + 1;
          $display("FAIL model dut%0d t=%0t actual dout=%0d tc=%0b wrap=%0b sat=%0b expected dout=%0d tc=%0b wrap=%0b sat=%0b",
                   k, $time, dout_a[k], tc_a[k], wrap_a[k], sat_a[k],
                   m_cnt[k], exp_tc, m_wrap[k], m_sat[k]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  initial begin
    int exp_up  [11];
    int exp_dn  [3];
    int exp_psc [9];
    int exp_gap [5];
    exp_up  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
    exp_dn  = '{1, 0, 9};
    exp_psc = '{0, 0, 1, 1, 1, 2, 2, 2, 3};
    exp_gap = '{3, 3, 3, 3, 4};

    tick();
    chk_en = 1'b1;
    chk("reset_dout", int'(dout_a[0]), 0);
    chk("reset_wrap", int'(wrap_a[0]), 0);
    chk("reset_sat", int'(sat_a[1]), 0);

    // Up count through the wrap point.
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      chk("up_dout", int'(dout_a[0]), exp_up[i]);
      chk("up_tc", int'(tc_a[0]), (exp_up[i] == 9) ? 1 : 0);
      chk("up_wrap", int'(wrap_a[0]), (exp_up[i] == 0) ? 1 : 0);
    end

    // Down count through zero.
    en = 1'b0; load = 1'b1; load_val = 4'd2;
    tick();
    chk("load2", int'(dout_a[0]), 2);
    load = 1'b0; en = 1'b1; up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dn_dout", int'(dout_a[0]), exp_dn[i]);
      chk("dn_wrap", int'(wrap_a[0]), (i == 2) ? 1 : 0);
    end

    // Saturating variant holds at the top.
    en = 1'b0; load = 1'b1; load_val = 4'd8;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat_dout", int'(dout_a[1]), 9);
      chk("sat_pulse", int'(sat_a[1]), (i > 0) ? 1 : 0);
      chk("sat_nowrap", int'(wrap_a[1]), 0);
    end

    // Prescale by 3, then a two-cycle enable gap.
    en = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("psc_dout", int'(dout_a[2]), exp_psc[i]);
    end
    for (int i = 0; i < 5; i++) begin
      en = (i == 1 || i == 2) ? 1'b0 : 1'b1;
      tick();
      chk("psc_gap", int'(dout_a[2]), exp_gap[i]);
    end

    // Priority and clamping.
    rst = 1'b1; load = 1'b1; clear = 1'b1; load_val = 4'd7;
    tick();
    chk("prio_rst", int'(dout_a[0]), 0);
    rst = 1'b0; clear = 1'b0; load_val = 4'd15;
    tick();
    chk("clamp15", int'(dout_a[0]), 9);
    clear = 1'b1;
    tick();
    chk("clear_over_load", int'(dout_a[0]), 0);

    // Reset in the middle of a prescale period.
    clear = 1'b0; load_val = 4'd5; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    chk("mid_pre", int'(dout_a[2]), 5);
    rst = 1'b1;
    tick();
    chk("mid_rst", int'(dout_a[2]), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_resume", int'(dout_a[2]), (i == 2) ? 1 : 0);
    end

    // Randomised traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 59) == 0);
      clear    = ($urandom_range(0, 29) == 0);
      load     = ($urandom_range(0, 14) == 0);
      en       = ($urandom_range(0, 3) != 0);
      load_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) up = ~up;
      tick();
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
